// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants and bus layout.
//
// Holds the default 800x600@60 Hz (40 MHz pixel clock) timing, the game
// field size the visible area must match, and the packed bus that every
// drawing stage passes along to the next one.
package vga_timing_pkg;

  // Game field size. The visible raster defaults below must equal these.
  localparam int GAME_WIDTH  = 800;
  localparam int GAME_HEIGHT = 600;

  // Default raster timing (pixels / lines).
  localparam int DEF_H_ACTIVE = GAME_WIDTH;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;   // H_TOTAL = 1056
  localparam int DEF_V_ACTIVE = GAME_HEIGHT;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 23;   // V_TOTAL = 628
  localparam bit DEF_SYNC_POL = 1'b1; // positive sync pulses

  // Counters are 11 bits wide, so H_TOTAL and V_TOTAL must not exceed 2047.
  localparam int CNT_W = 11;
  localparam int RGB_W = 12;

  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic [RGB_W-1:0] rgb;
  } vga_bus_t;

  localparam int VGA_BUS_SIZE = $bits(vga_bus_t);

  // Pack the individual fields into the bus word.
  function automatic vga_bus_t vga_bus_merge(
    input logic [CNT_W-1:0] hcount,
    input logic [CNT_W-1:0] vcount,
    input logic             hsync,
    input logic             vsync,
    input logic [RGB_W-1:0] rgb
  );
    vga_bus_t b;
    b.hcount = hcount;
    b.vcount = vcount;
    b.hsync  = hsync;
    b.vsync  = vsync;
    b.rgb    = rgb;
    return b;
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// VGA bus interface between the timing source and the drawing chain.
//
// Signals:
//   vga_bus     packed hcount/vcount/hsync/vsync/rgb word (see vga_bus_t)
//   hblnk       high while hcount >= H_ACTIVE
//   vblnk       high while vcount >= V_ACTIVE
//   frame_start one-cycle strobe while the bus shows pixel (0,0)
// The master modport drives everything; the slave modport only observes.
interface vga_timing_if;
  import vga_timing_pkg::*;

  logic [VGA_BUS_SIZE-1:0] vga_bus;
  logic                    hblnk;
  logic                    vblnk;
  logic                    frame_start;

  modport master (output vga_bus, output hblnk, output vblnk, output frame_start);
  modport slave  (input  vga_bus, input  hblnk, input  vblnk, input  frame_start);

endinterface

// File: rtl/vga_timing.sv
// VGA raster timing source.
//
// Generates the horizontal/vertical raster counters, sync pulses and
// blanking flags and launches them on the VGA bus with rgb forced to black.
// Also emits a one-cycle frame_start strobe while the bus shows (0,0).
//
// Ports:
//   clk          pixel clock (single clock domain)
//   rst          asynchronous, active-low reset
//   vga_bus_out  master side of vga_timing_if (bus, hblnk, vblnk, frame_start)
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = DEF_SYNC_POL
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master vga_bus_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Decode thresholds sized to the counters to keep every compare same-width.
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] vcount_q, vcount_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             hblnk_q, hblnk_d;
  logic             vblnk_q, vblnk_d;
  logic             frame_start_q, frame_start_d;
  logic             h_wrap;

  // Flags are decoded from the *next* counter values so that, once
  // registered, they line up with the counts they describe on the bus.
  always_comb begin
    h_wrap   = (hcount_q == H_LAST);
    hcount_d = h_wrap ? '0 : hcount_q + 1'b1;
    vcount_d = vcount_q;
    if (h_wrap) begin
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
    end

    hsync_d       = ((hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    // vcount only moves on an H wrap, so vsync toggles with hcount = 0.
    vsync_d       = ((vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    hblnk_d       = (hcount_d >= H_VIS);
    vblnk_d       = (vcount_d >= V_VIS);
    frame_start_d = (hcount_d == '0) && (vcount_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      // Reset state shows (0,0) but is not a frame start; the first strobe
      // comes one full frame after release.
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga_bus_out.vga_bus     = vga_bus_merge(hcount_q, vcount_q, hsync_q, vsync_q, '0);
  assign vga_bus_out.hblnk       = hblnk_q;
  assign vga_bus_out.vblnk       = vblnk_q;
  assign vga_bus_out.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Directed testbench for vga_timing.
// Instance A uses the default 800x600 timing for line-level checks.
// Instance B uses a reduced raster (25 x 16 = 400 cycles per frame) so that
// frame-level behaviour (frame_start period, vsync, vblnk, frame wrap) can be
// checked within a short run.
module tb_vga_timing;
  import vga_timing_pkg::*;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   tests;
  int   fails;

  vga_timing_if if_a ();
  vga_timing_if if_b ();

  vga_timing dut_a (
    .clk         (clk),
    .rst         (rst_a),
    .vga_bus_out (if_a.master)
  );

  vga_timing #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
    .V_ACTIVE (10), .V_FP (1), .V_SYNC (2), .V_BP (3),
    .SYNC_POL (1'b1)
  ) dut_b (
    .clk         (clk),
    .rst         (rst_b),
    .vga_bus_out (if_b.master)
  );

  vga_bus_t ba;
  vga_bus_t bb;
  assign ba = if_a.vga_bus;
  assign bb = if_b.vga_bus;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_a(input int h, input int v, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (int'(ba.hcount) == h && int'(ba.vcount) == v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b0;
    rst_b = 1'b0;
    #3;
    tests++; if (ba.hcount !== 11'd0) begin fails++; $display("FAIL reset_hcount: got %0d expected 0", ba.hcount); end
    tests++; if (ba.vcount !== 11'd0) begin fails++; $display("FAIL reset_vcount: got %0d expected 0", ba.vcount); end
    tick(); tick();
    tests++; if (ba.hsync !== 1'b0) begin fails++; $display("FAIL reset_hsync: got %b expected 0", ba.hsync); end
    tests++; if (ba.vsync !== 1'b0) begin fails++; $display("FAIL reset_vsync: got %b expected 0", ba.vsync); end
    tests++; if (ba.rgb !== 12'h000) begin fails++; $display("FAIL reset_rgb: got %h expected 000", ba.rgb); end
    tests++; if (if_a.hblnk !== 1'b0 || if_a.vblnk !== 1'b0) begin fails++; $display("FAIL reset_blnk: got h=%b v=%b expected 0 0", if_a.hblnk, if_a.vblnk); end
    tests++; if (if_a.frame_start !== 1'b0) begin fails++; $display("FAIL reset_frame_start: got %b expected 0", if_a.frame_start); end
    tests++; if (ba.hcount !== 11'd0) begin fails++; $display("FAIL reset_hold: got hcount %0d expected 0", ba.hcount); end
    $display("[TB] reset: bus=(%0d,%0d) hs=%b vs=%b", ba.hcount, ba.vcount, ba.hsync, ba.vsync);
  endtask

  task automatic test_first_edge();
    rst_a = 1'b1;
    tick();
    tests++; if (ba.hcount !== 11'd1 || ba.vcount !== 11'd0) begin fails++; $display("FAIL first_edge_pos: got (%0d,%0d) expected (1,0)", ba.hcount, ba.vcount); end
    tests++; if (if_a.frame_start !== 1'b0) begin fails++; $display("FAIL first_edge_fs: got %b expected 0", if_a.frame_start); end
    $display("[TB] first edge: bus=(%0d,%0d)", ba.hcount, ba.vcount);
  endtask

  task automatic test_line_scan();
    int hs_cnt = 0;
    int hs_first = -1;
    int hb_rise = -1;
    int hb_fall = -1;
    int seq_err = 0;
    int vflag_cnt = 0;
    int ph, pv, eh, ev;
    logic prev_hb;
    bit done = 1'b0;
    ph = int'(ba.hcount);
    pv = int'(ba.vcount);
    prev_hb = if_a.hblnk;
    for (int i = 0; i < 3000 && !done; i++) begin
      tick();
      eh = (ph == 1055) ? 0 : ph + 1;
      ev = (ph == 1055) ? pv + 1 : pv;
      if (int'(ba.hcount) != eh || int'(ba.vcount) != ev) seq_err++;
      if (ba.vcount == 11'd0 && ba.hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(ba.hcount);
      end
      if (if_a.hblnk && !prev_hb && hb_rise < 0) hb_rise = int'(ba.hcount);
      if (!if_a.hblnk && prev_hb && hb_fall < 0) hb_fall = int'(ba.hcount);
      if (if_a.vblnk || ba.vsync || ba.rgb != 12'h000) vflag_cnt++;
      prev_hb = if_a.hblnk;
      ph = int'(ba.hcount);
      pv = int'(ba.vcount);
      if (ba.vcount == 11'd2) done = 1'b1;
    end
    tests++; if (!done) begin fails++; $display("FAIL line_timeout: got v=%0d expected 2", ba.vcount); end
    tests++; if (seq_err !== 0) begin fails++; $display("FAIL line_sequence: got %0d bad steps expected 0", seq_err); end
    tests++; if (hs_cnt !== 128) begin fails++; $display("FAIL hsync_width: got %0d expected 128", hs_cnt); end
    tests++; if (hs_first !== 840) begin fails++; $display("FAIL hsync_start: got %0d expected 840", hs_first); end
    tests++; if (hb_rise !== 800) begin fails++; $display("FAIL hblnk_rise: got %0d expected 800", hb_rise); end
    tests++; if (hb_fall !== 0) begin fails++; $display("FAIL hblnk_fall: got %0d expected 0", hb_fall); end
    tests++; if (vflag_cnt !== 0) begin fails++; $display("FAIL line_vflags: got %0d active samples expected 0", vflag_cnt); end
    $display("[TB] line scan: hs_width=%0d hs_start=%0d hb_rise=%0d hb_fall=%0d", hs_cnt, hs_first, hb_rise, hb_fall);
  endtask

  task automatic test_line_wrap();
    bit ok;
    wait_a(1055, 10, 12000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL wrap_reach: got (%0d,%0d) expected (1055,10)", ba.hcount, ba.vcount); end
    tick();
    tests++; if (ba.hcount !== 11'd0 || ba.vcount !== 11'd11) begin fails++; $display("FAIL line_wrap: got (%0d,%0d) expected (0,11)", ba.hcount, ba.vcount); end
    tests++; if (if_a.hblnk !== 1'b0 || if_a.frame_start !== 1'b0) begin fails++; $display("FAIL line_wrap_flags: got hb=%b fs=%b expected 0 0", if_a.hblnk, if_a.frame_start); end
    $display("[TB] line wrap: (1055,10) -> (%0d,%0d)", ba.hcount, ba.vcount);
  endtask

  task automatic test_async_reset();
    bit ok;
    wait_a(500, 11, 2000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL areset_reach: got (%0d,%0d) expected (500,11)", ba.hcount, ba.vcount); end
    #2 rst_a = 1'b0;
    #1;
    tests++; if (ba.hcount !== 11'd0 || ba.vcount !== 11'd0) begin fails++; $display("FAIL areset_pos: got (%0d,%0d) expected (0,0)", ba.hcount, ba.vcount); end
    tests++; if (ba.hsync !== 1'b0 || ba.vsync !== 1'b0 || if_a.hblnk !== 1'b0 || if_a.vblnk !== 1'b0 || if_a.frame_start !== 1'b0) begin
      fails++; $display("FAIL areset_flags: got hs=%b vs=%b hb=%b vb=%b fs=%b expected all 0", ba.hsync, ba.vsync, if_a.hblnk, if_a.vblnk, if_a.frame_start);
    end
    tick();
    rst_a = 1'b1;
    tick();
    tests++; if (ba.hcount !== 11'd1 || ba.vcount !== 11'd0) begin fails++; $display("FAIL areset_restart: got (%0d,%0d) expected (1,0)", ba.hcount, ba.vcount); end
    $display("[TB] async reset: restart at (%0d,%0d)", ba.hcount, ba.vcount);
  endtask

  // Reduced raster: H_TOTAL=25, V_TOTAL=16, hsync h 18..21, vsync v 11..12,
  // vblnk v 10..15, frame of 400 cycles.
  task automatic test_frame();
    int fs_first = -1;
    int fs_second = -1;
    int fs_cnt = 0;
    int fs_bad = 0;
    int vs_cnt = 0;
    int vs_rise_h = -1;
    int vs_rise_v = -1;
    int vb_cnt = 0;
    int vb_rise_v = -1;
    int h399 = -1, v399 = -1;
    logic prev_vs = 1'b0;
    logic prev_vb = 1'b0;
    rst_b = 1'b1;
    for (int c = 1; c <= 820; c++) begin
      tick();
      if (if_b.frame_start) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = c;
        else if (fs_second < 0) fs_second = c;
        if (bb.hcount != 11'd0 || bb.vcount != 11'd0) fs_bad++;
      end
      if (c < 400) begin
        if (bb.vsync) vs_cnt++;
        if (if_b.vblnk) vb_cnt++;
        if (bb.vsync && !prev_vs && vs_rise_h < 0) begin vs_rise_h = int'(bb.hcount); vs_rise_v = int'(bb.vcount); end
        if (if_b.vblnk && !prev_vb && vb_rise_v < 0) vb_rise_v = int'(bb.vcount);
      end
      if (c == 399) begin h399 = int'(bb.hcount); v399 = int'(bb.vcount); end
      prev_vs = bb.vsync;
      prev_vb = if_b.vblnk;
    end
    tests++; if (fs_first !== 400) begin fails++; $display("FAIL fs_first: got cycle %0d expected 400", fs_first); end
    tests++; if (fs_second !== 800) begin fails++; $display("FAIL fs_period: got cycle %0d expected 800", fs_second); end
    tests++; if (fs_cnt !== 2) begin fails++; $display("FAIL fs_count: got %0d expected 2", fs_cnt); end
    tests++; if (fs_bad !== 0) begin fails++; $display("FAIL fs_position: got %0d strobes off (0,0) expected 0", fs_bad); end
    tests++; if (h399 !== 24 || v399 !== 15) begin fails++; $display("FAIL frame_last: got (%0d,%0d) expected (24,15)", h399, v399); end
    tests++; if (vs_cnt !== 50) begin fails++; $display("FAIL vsync_width: got %0d cycles expected 50", vs_cnt); end
    tests++; if (vs_rise_h !== 0 || vs_rise_v !== 11) begin fails++; $display("FAIL vsync_rise: got (%0d,%0d) expected (0,11)", vs_rise_h, vs_rise_v); end
    tests++; if (vb_cnt !== 150) begin fails++; $display("FAIL vblnk_width: got %0d cycles expected 150", vb_cnt); end
    tests++; if (vb_rise_v !== 10) begin fails++; $display("FAIL vblnk_rise: got v=%0d expected 10", vb_rise_v); end
    $display("[TB] frame: fs at %0d,%0d vs_cycles=%0d vb_cycles=%0d", fs_first, fs_second, vs_cnt, vb_cnt);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    test_reset();
    test_first_edge();
    test_line_scan();
    test_line_wrap();
    test_async_reset();
    test_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Source end of the VGA bus: generates the 800x600@60 Hz (40 MHz pixel clock) raster counters, sync pulses and blanking flags, and launches them on `vga_bus_out` for the chain of drawing stages (background, sprites, time bar, …) that consume `vga_bus_in`. It drives `rgb` to black. Every overlay downstream re-registers the bus one stage each. It also emits a one-cycle frame strobe for game logic that updates once per frame.

## Interface
- `H_ACTIVE`, 800: visible pixels per line (equals `GAME_WIDTH`)
- `H_FP`, 40: horizontal front porch
- `H_SYNC`, 128: hsync pulse width
- `H_BP`, 88: horizontal back porch (H_TOTAL = 1056)
- `V_ACTIVE`, 600: visible lines (equals `GAME_HEIGHT`)
- `V_FP`, 1: vertical front porch (lines)
- `V_SYNC`, 4: vsync pulse width (lines)
- `V_BP`, 23: vertical back porch (V_TOTAL = 628)
- `SYNC_POL`, 1: active level of hsync/vsync (1 = positive, per 800x600@60)
- `clk`  in  1  pixel clock, 40 MHz; one clock domain, no other clock
- `rst`  in  1  asynchronous, active-low reset
- `vga_bus_out`  out  `VGA_BUS_SIZE`  hcount[10:0], vcount[10:0], hsync, vsync, rgb[11:0], packed by `VGA_BUS_MERGE`
- `hblnk`  out  1  high while hcount ≥ H_ACTIVE
- `vblnk`  out  1  high while vcount ≥ V_ACTIVE
- `frame_start`  out  1  one-cycle strobe, high while the bus shows (0,0)

## Operation
- Free-running H counter 0 … H_TOTAL−1. At H_TOTAL−1 it wraps to 0 and the V counter advances.
- V counter 0 … V_TOTAL−1. It advances only on an H wrap. At V_TOTAL−1 together with an H wrap, it wraps to 0.
- Bus fields are registered copies of the counter state. Nothing on the output is combinational from the counters.
- hsync is at SYNC_POL while hcount is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC−1], i.e. [840, 967] with defaults. Otherwise it is at !SYNC_POL.
- vsync is at SYNC_POL while vcount is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC−1], i.e. [601, 604]. It is line-aligned: it changes in the same cycle that hcount shows 0.
- hblnk = (hcount ≥ H_ACTIVE). vblnk = (vcount ≥ V_ACTIVE). Both are aligned with the bus fields they describe.
- rgb = 12'h000 always. The colour is filled in by downstream stages.
- frame_start = 1 exactly when the bus shows hcount = 0, vcount = 0.
- Width rule: counters are 11 bits. Any parameter set with H_TOTAL or V_TOTAL > 2047 is illegal.

## Timing
- Reset (rst = 0, async): hcount = 0, vcount = 0, hsync = vsync = !SYNC_POL, rgb = 0, hblnk = vblnk = 0, frame_start = 0.
- First rising edge after release: bus shows (1,0). Pixel (0,0) appears again after H_TOTAL·V_TOTAL = 663 168 cycles. The first `frame_start` pulse is at that point, not at reset release.
- Throughput: one pixel per clk, with no stalls and no gaps.
- Sync/blank flags and counts are mutually consistent in every cycle; they are all registered in the same stage.
- Reset asserted mid-frame: all outputs go to reset values immediately, without waiting for a clock edge. Counting resumes from (0,0) as for a fresh reset.
- Frame period is exactly 663 168 cycles (16.579 ms at 40 MHz). frame_start period is identical.

## Structure
- Timing constants (the H_/V_ defaults, VGA_BUS_SIZE, the bus split/merge macros) live in the shared `macros.vh`, alongside `GAME_WIDTH`/`GAME_HEIGHT`. The defaults must equal those values.
- Single flat module. No sub-module is warranted: two cascaded counters plus a decode stage.

## Test plan
- Reset, then release, then 2 frames: bus shows (1,0) one edge after release; frame_start first fires at cycle 663 168, then every 663 168 cycles.
- Line scan: hsync active for exactly 128 cycles, starting at hcount = 840. hblnk rises at hcount = 800 and falls at 0.
- Frame scan: vsync active for exactly 4 lines, rising with hcount = 0 at vcount = 601. vblnk is high for vcount 600–627.
- Wrap: at (1055, 627) the next cycle is (0,0) with frame_start = 1. At (1055, 10) the next cycle is (0, 11).
- Async reset mid-frame at (500, 300): outputs go to reset values before the next clk edge. After release the scan restarts at (1,0).
- Daisy-chain with a time-bar stage: that stage's `vga_bus_out` equals this block's bus delayed by one cycle outside its bar region.
